// File: rtl/alu_sys_pkg.sv
// Shared types and constants for the UART-driven ALU command path.
// The frame check byte is the XOR of the three payload bytes.
package alu_sys_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_OP  = 3'd1,
      ST_GET_A   = 3'd2,
      ST_GET_B   = 3'd3,
      ST_GET_CHK = 3'd4,
      ST_ISSUE   = 3'd5
   } state_e;

   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
   localparam int unsigned OP_W          = 4;

   function automatic logic [7:0] frame_chk(input logic [7:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
      return op ^ a ^ b;
   endfunction

endpackage

// File: rtl/interbyte_timer.sv
// Idle-clock counter between received bytes; expired flags the last allowed idle clock.
// Clear has priority over enable, and an expiring cycle restarts the count.
module interbyte_timer #(
   parameter int unsigned LIMIT = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign expired = en && !clr && (cnt_q == CW'(LIMIT - 1));

   // Next count: clear, restart on expiry, or advance while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr || expired) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses SYNC/OP/A/B/CHK byte frames into ALU commands with a valid/ready handshake.
// All outputs come straight from flops; rx_valid and cmd_ready only steer next state.
module uart_cmd_parser
   import alu_sys_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
   parameter int unsigned NUM_OPS        = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid,
   input  logic            auth,
   input  logic            cmd_ready,
   output logic            cmd_valid,
   output logic [OP_W-1:0] cmd_op,
   output logic [7:0]      cmd_a,
   output logic [7:0]      cmd_b,
   output logic            err_chk,
   output logic            err_op,
   output logic            err_auth,
   output logic            err_timeout,
   output logic            err_overrun,
   output logic [7:0]      frame_cnt
);

   state_e          state_q, state_d;
   logic [7:0]      op_q, op_d, a_q, a_d, b_q, b_d;
   logic [OP_W-1:0] cmd_op_q, cmd_op_d;
   logic [7:0]      cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
   logic            cmd_valid_q, cmd_valid_d;
   logic            err_chk_q, err_chk_d, err_op_q, err_op_d, err_auth_q, err_auth_d;
   logic            err_tmo_q, err_tmo_d, err_ovr_q, err_ovr_d;
   logic [7:0]      frame_cnt_q, frame_cnt_d;
   logic            timing_s, tmr_clr_s, tmr_expired_s;

   assign timing_s  = (state_q == ST_GET_OP) || (state_q == ST_GET_A) ||
                      (state_q == ST_GET_B)  || (state_q == ST_GET_CHK);
   assign tmr_clr_s = rx_valid || !timing_s;

   interbyte_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (tmr_clr_s),
      .en      (timing_s),
      .expired (tmr_expired_s)
   );

   // Next-state and output decode; a received byte always wins over a timeout.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      cmd_op_d    = cmd_op_q;
      cmd_a_d     = cmd_a_q;
      cmd_b_d     = cmd_b_q;
      err_chk_d   = 1'b0;
      err_op_d    = 1'b0;
      err_auth_d  = 1'b0;
      err_tmo_d   = 1'b0;
      err_ovr_d   = 1'b0;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_d = ST_GET_OP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GET_OP, ST_GET_A, ST_GET_B: begin
            if (rx_valid) begin
               if (state_q == ST_GET_OP) begin
                  op_d    = rx_data;
                  state_d = ST_GET_A;
               end else if (state_q == ST_GET_A) begin
                  a_d     = rx_data;
                  state_d = ST_GET_B;
               end else begin
                  b_d     = rx_data;
                  state_d = ST_GET_CHK;
               end
            end else if (tmr_expired_s) begin
               err_tmo_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end
         ST_GET_CHK: begin
            if (rx_valid) begin
               state_d = ST_IDLE;
               if (rx_data != frame_chk(op_q, a_q, b_q)) begin
                  err_chk_d = 1'b1;
               end else if (32'(op_q) >= NUM_OPS) begin
                  err_op_d = 1'b1;
               end else if (!auth) begin
                  err_auth_d = 1'b1;
               end else begin
                  state_d  = ST_ISSUE;
                  cmd_op_d = op_q[OP_W-1:0];
                  cmd_a_d  = a_q;
                  cmd_b_d  = b_q;
               end
            end else if (tmr_expired_s) begin
               err_tmo_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_GET_CHK;
            end
         end
         ST_ISSUE: begin
            err_ovr_d = rx_valid;
            if (cmd_ready) begin
               state_d     = ST_IDLE;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      cmd_valid_d = (state_d == ST_ISSUE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= 8'h00;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         cmd_op_q    <= '0;
         cmd_a_q     <= 8'h00;
         cmd_b_q     <= 8'h00;
         cmd_valid_q <= 1'b0;
         err_chk_q   <= 1'b0;
         err_op_q    <= 1'b0;
         err_auth_q  <= 1'b0;
         err_tmo_q   <= 1'b0;
         err_ovr_q   <= 1'b0;
         frame_cnt_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         cmd_op_q    <= cmd_op_d;
         cmd_a_q     <= cmd_a_d;
         cmd_b_q     <= cmd_b_d;
         cmd_valid_q <= cmd_valid_d;
         err_chk_q   <= err_chk_d;
         err_op_q    <= err_op_d;
         err_auth_q  <= err_auth_d;
         err_tmo_q   <= err_tmo_d;
         err_ovr_q   <= err_ovr_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_op      = cmd_op_q;
   assign cmd_a       = cmd_a_q;
   assign cmd_b       = cmd_b_q;
   assign err_chk     = err_chk_q;
   assign err_op      = err_op_q;
   assign err_auth    = err_auth_q;
   assign err_timeout = err_tmo_q;
   assign err_overrun = err_ovr_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed-vector bench for uart_cmd_parser; inputs change and outputs are sampled on the falling edge.
// Error vector order: {chk, op, auth, timeout, overrun}.
module tb_uart_cmd_parser;

   localparam int unsigned TMO = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       auth;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [3:0] cmd_op;
   logic [7:0] cmd_a, cmd_b;
   logic       err_chk, err_op, err_auth, err_timeout, err_overrun;
   logic [7:0] frame_cnt;
   logic [4:0] errs;
   logic [7:0] exp_cnt;
   logic       seen;
   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   assign errs = {err_chk, err_op, err_auth, err_timeout, err_overrun};

   always #5 clk = ~clk;

   uart_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .NUM_OPS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .auth        (auth),
      .cmd_ready   (cmd_ready),
      .cmd_valid   (cmd_valid),
      .cmd_op      (cmd_op),
      .cmd_a       (cmd_a),
      .cmd_b       (cmd_b),
      .err_chk     (err_chk),
      .err_op      (err_op),
      .err_auth    (err_auth),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun),
      .frame_cnt   (frame_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] c);
      send(8'hA5);
      send(op);
      send(a);
      send(b);
      send(c);
   endtask

   initial begin
      reset     = 1'b1;
      rx_valid  = 1'b0;
      rx_data   = 8'h00;
      auth      = 1'b0;
      cmd_ready = 1'b0;
      exp_cnt   = 8'd0;
      tick();
      tick();
      check("rst_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd",   {12'd0, cmd_op, cmd_a, cmd_b}, 32'd0);
      check("rst_errs",  32'(errs), 32'd0);
      check("rst_cnt",   32'(frame_cnt), 32'd0);
      reset = 1'b0;
      tick();

      // Basic frame, ready already high: valid for exactly one cycle
      auth = 1'b1;
      cmd_ready = 1'b1;
      send_frame(8'h02, 8'h10, 8'h03, 8'h11);
      check("f1_valid", 32'(cmd_valid), 32'd1);
      check("f1_cmd",   {12'd0, cmd_op, cmd_a, cmd_b}, {12'd0, 4'h2, 8'h10, 8'h03});
      check("f1_errs",  32'(errs), 32'd0);
      tick();
      exp_cnt = exp_cnt + 8'd1;
      check("f1_drop",  32'(cmd_valid), 32'd0);
      check("f1_cnt",   32'(frame_cnt), 32'(exp_cnt));

      // Bad checksum, then a good frame
      send_frame(8'h02, 8'h10, 8'h03, 8'h12);
      check("chk_errs",  32'(errs), 32'b10000);
      check("chk_valid", 32'(cmd_valid), 32'd0);
      tick();
      check("chk_clear", 32'(errs), 32'd0);
      send_frame(8'h01, 8'h05, 8'h05, 8'h01);
      check("f2_cmd", {11'd0, cmd_valid, cmd_op, cmd_a, cmd_b}, {11'd0, 1'b1, 4'h1, 8'h05, 8'h05});
      tick();
      exp_cnt = exp_cnt + 8'd1;
      check("f2_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // Locked, then illegal opcode
      auth = 1'b0;
      send_frame(8'h00, 8'h01, 8'h01, 8'h00);
      check("auth_errs",  32'(errs), 32'b00100);
      check("auth_valid", 32'(cmd_valid), 32'd0);
      auth = 1'b1;
      send_frame(8'h09, 8'h00, 8'h00, 8'h09);
      check("op_errs",  32'(errs), 32'b01000);
      check("op_valid", 32'(cmd_valid), 32'd0);
      tick();
      check("op_clear", 32'(errs), 32'd0);

      // Inter-byte timeout after A5,03
      send(8'hA5);
      send(8'h03);
      seen = 1'b0;
      for (int i = 0; i < TMO - 1; i++) begin
         tick();
         if (errs != 5'd0) seen = 1'b1;
      end
      check("tmo_early", 32'(seen), 32'd0);
      tick();
      check("tmo_errs", 32'(errs), 32'b00010);
      tick();
      check("tmo_clear", 32'(errs), 32'd0);
      send(8'h03);
      send_frame(8'h01, 8'h02, 8'h03, 8'h00);
      check("tmo_idle", {11'd0, cmd_valid, cmd_op, cmd_a, cmd_b}, {11'd0, 1'b1, 4'h1, 8'h02, 8'h03});
      check("tmo_idle_errs", 32'(errs), 32'd0);
      tick();
      exp_cnt = exp_cnt + 8'd1;

      // Overrun while the command is held
      cmd_ready = 1'b0;
      send_frame(8'h06, 8'h0A, 8'h0B, 8'h07);
      tick();
      tick();
      send(8'h55);
      check("ovr_errs", 32'(errs), 32'b00001);
      check("ovr_hold", {11'd0, cmd_valid, cmd_op, cmd_a, cmd_b}, {11'd0, 1'b1, 4'h6, 8'h0A, 8'h0B});
      auth = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("ovr_still", {11'd0, cmd_valid, cmd_op, cmd_a, cmd_b, errs != 5'd0}, {11'd0, 1'b1, 4'h6, 8'h0A, 8'h0B, 1'b0});
      auth = 1'b1;
      cmd_ready = 1'b1;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      check("ovr_issue", {23'd0, cmd_valid, frame_cnt}, {23'd0, 1'b0, exp_cnt});

      // Overrun in the same cycle as the handshake
      cmd_ready = 1'b0;
      send_frame(8'h07, 8'hFF, 8'h00, 8'hF8);
      cmd_ready = 1'b1;
      send(8'hA5);
      exp_cnt = exp_cnt + 8'd1;
      check("ovr_rdy", {18'd0, errs, cmd_valid, frame_cnt}, {18'd0, 5'b00001, 1'b0, exp_cnt});

      // Sync byte inside a frame is payload
      send_frame(8'h01, 8'hA5, 8'hA5, 8'h01);
      check("sync_data", {11'd0, cmd_valid, cmd_op, cmd_a, cmd_b}, {11'd0, 1'b1, 4'h1, 8'hA5, 8'hA5});
      tick();

      // Reset mid-frame, coinciding with a byte
      send(8'hA5);
      send(8'h04);
      send(8'h07);
      reset = 1'b1;
      rx_data = 8'h01;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      check("rst_mid", {22'd0, errs, cmd_valid, frame_cnt}, 32'd0);
      reset = 1'b0;
      tick();
      check("rst_after", 32'(errs), 32'd0);
      exp_cnt = 8'd0;
      send_frame(8'h04, 8'h07, 8'h01, 8'h02);
      check("rst_frame", {11'd0, cmd_valid, cmd_op, cmd_a, cmd_b}, {11'd0, 1'b1, 4'h4, 8'h07, 8'h01});
      tick();
      exp_cnt = exp_cnt + 8'd1;
      check("rst_cnt1", 32'(frame_cnt), 32'(exp_cnt));

      // 255 more frames -> counter wraps to zero
      for (int i = 0; i < 255; i++) begin
         send_frame(8'h03, i[7:0], 8'h00, 8'h03 ^ i[7:0]);
         tick();
         exp_cnt = exp_cnt + 8'd1;
         if (i == 253) check("cnt_255", 32'(frame_cnt), 32'd255);
      end
      check("cnt_wrap", 32'(frame_cnt), 32'(exp_cnt));
      check("cnt_zero", 32'(frame_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
